// File: rtl/fpu_issue_sched.sv
// fpu_issue_sched: hazard checks and start pulses for the multi-cycle FP units,
// plus the writeback-slot queue that sequences the FPU register-file write port.
module fpu_issue_sched #(
    parameter int LAT_ADD  = 3,
    parameter int LAT_MUL  = 2,
    parameter int LAT_DIV  = 8,
    parameter int LAT_MISC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dec_valid,
    input  logic       dec_is_fpu,
    input  logic [2:0] dec_fop,
    input  logic [5:0] dec_rs1,
    input  logic [5:0] dec_rs2,
    input  logic       dec_rs2_en,
    input  logic [6:0] dec_rd,
    input  logic       n_stall,
    input  logic       flush,
    output logic       iss_ready,
    output logic       add_start,
    output logic       mul_start,
    output logic       div_start,
    output logic       misc_start,
    output logic       wb_valid,
    output logic [5:0] wb_rd,
    output logic [1:0] wb_src,
    output logic       fpu_busy
);
    localparam int MAX_AM = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
    localparam int MAX_DM = (LAT_DIV > LAT_MISC) ? LAT_DIV : LAT_MISC;
    localparam int MAXL   = (MAX_AM > MAX_DM) ? MAX_AM : MAX_DM;

    typedef struct packed {
        logic       v;
        logic       rd_valid;
        logic [5:0] rd;
        logic [1:0] src;
    } slot_t;

    slot_t       slots [0:MAXL];
    logic [63:0] pending;
    logic [63:0] pending_next;
    logic [3:0]  div_cnt;
    logic [3:0]  lat;
    logic [3:0]  wr_idx;
    logic [1:0]  src;
    logic        is_div;
    logic        hazard;
    logic        accept;
    logic        fpu_accept;
    slot_t       new_slot;

    always_comb begin
        lat    = 4'(LAT_MISC);
        src    = 2'b11;
        is_div = 1'b0;
        unique case (dec_fop)
            3'b000, 3'b001: begin
                lat = 4'(LAT_ADD);
                src = 2'b00;
            end
            3'b010: begin
                lat = 4'(LAT_MUL);
                src = 2'b01;
            end
            3'b011, 3'b100: begin
                lat    = 4'(LAT_DIV);
                src    = 2'b10;
                is_div = 1'b1;
            end
            default: ;
        endcase
    end

    // slot[lat] shifts into the entry a new op would claim: two writebacks collide
    always_comb begin
        hazard = pending[dec_rs1]
               | (dec_rs2_en & pending[dec_rs2])
               | (dec_rd[6] & pending[dec_rd[5:0]]);
        if (dec_is_fpu) begin
            hazard = hazard | slots[lat].v
                   | (is_div & (div_cnt != 4'd0));
        end
    end

    assign iss_ready  = ~hazard;
    assign accept     = dec_valid & ~hazard & n_stall & ~flush & ~rst;
    assign fpu_accept = accept & dec_is_fpu;

    assign add_start  = fpu_accept & (src == 2'b00);
    assign mul_start  = fpu_accept & (src == 2'b01);
    assign div_start  = fpu_accept & (src == 2'b10);
    assign misc_start = fpu_accept & (src == 2'b11);

    assign wr_idx   = lat - 4'd1;
    assign new_slot = '{v: 1'b1, rd_valid: dec_rd[6],
                        rd: dec_rd[5:0], src: src};

    assign wb_valid = slots[0].v & slots[0].rd_valid;
    assign wb_rd    = slots[0].rd;
    assign wb_src   = slots[0].src;

    always_comb begin
        pending_next = pending;
        if (wb_valid) begin
            pending_next[wb_rd] = 1'b0;
        end
        if (fpu_accept & dec_rd[6]) begin
            pending_next[dec_rd[5:0]] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_comb begin
        fpu_busy = (div_cnt != 4'd0);
        for (int k = 0; k <= MAXL; k++) begin
            fpu_busy = fpu_busy | slots[k].v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= MAXL; k++) begin
                slots[k] <= '0;
            end
            pending <= '0;
            div_cnt <= '0;
        end else begin
            for (int k = 0; k < MAXL; k++) begin
                slots[k] <= slots[k+1];
            end
            slots[MAXL] <= '0;
            if (fpu_accept) begin
                slots[wr_idx] <= new_slot;
            end
            if (fpu_accept & is_div) begin
                div_cnt <= 4'(LAT_DIV - 1);
            end else if (div_cnt != 4'd0) begin
                div_cnt <= div_cnt - 4'd1;
            end
            pending <= pending_next;
        end
    end
endmodule

// File: tb/tb_fpu_issue_sched.sv
// tb_fpu_issue_sched: directed scenarios and random traffic against a
// cycle-indexed reference model of issue, writeback and scoreboard timing.
module tb_fpu_issue_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dec_valid = 1'b0;
    logic       dec_is_fpu = 1'b0;
    logic [2:0] dec_fop = '0;
    logic [5:0] dec_rs1 = '0;
    logic [5:0] dec_rs2 = '0;
    logic       dec_rs2_en = 1'b0;
    logic [6:0] dec_rd = '0;
    logic       n_stall = 1'b1;
    logic       flush = 1'b0;
    logic       iss_ready, add_start, mul_start, div_start, misc_start;
    logic       wb_valid, fpu_busy;
    logic [5:0] wb_rd;
    logic [1:0] wb_src;
    logic [14:0] dut_v;

    always #5 clk = ~clk;

    fpu_issue_sched dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_is_fpu(dec_is_fpu),
        .dec_fop(dec_fop), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs2_en(dec_rs2_en), .dec_rd(dec_rd),
        .n_stall(n_stall), .flush(flush),
        .iss_ready(iss_ready), .add_start(add_start),
        .mul_start(mul_start), .div_start(div_start),
        .misc_start(misc_start), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_src(wb_src), .fpu_busy(fpu_busy)
    );

    assign dut_v = {iss_ready, add_start, mul_start, div_start,
                    misc_start, wb_valid, wb_rd, wb_src, fpu_busy};

    int checks = 0;
    int errors = 0;

    // model: writebacks keyed by the absolute cycle they appear on the port
    typedef struct {
        bit       rdv;
        bit [5:0] rd;
        bit [1:0] src;
    } wbr_t;
    wbr_t        wb_at [int];
    int          pend_until [64];
    int          div_free;
    int          last_wb;
    int          now;
    bit          exp_acc;
    logic [14:0] exp_v;

    function automatic int lat_of(logic [2:0] f);
        case (f)
            3'd0, 3'd1: return 3;
            3'd2:       return 2;
            3'd3, 3'd4: return 8;
            default:    return 1;
        endcase
    endfunction

    function automatic int cls_of(logic [2:0] f);
        case (f)
            3'd0, 3'd1: return 0;
            3'd2:       return 1;
            3'd3, 3'd4: return 2;
            default:    return 3;
        endcase
    endfunction

    function automatic bit pend(int r);
        return (r != 0) && (pend_until[r] >= now);
    endfunction

    task automatic model_clear();
        wb_at.delete();
        foreach (pend_until[i]) pend_until[i] = -1;
        div_free = 0;
        last_wb  = -1;
    endtask

    task automatic model_eval();
        int       L;
        int       c;
        bit       haz;
        bit [3:0] st;
        bit       wv;
        bit [5:0] wr;
        bit [1:0] ws;
        bit       busy;
        L   = lat_of(dec_fop);
        c   = cls_of(dec_fop);
        haz = pend(int'(dec_rs1))
           || (dec_rs2_en && pend(int'(dec_rs2)))
           || (dec_rd[6] && pend(int'(dec_rd[5:0])))
           || (dec_is_fpu && wb_at.exists(now + L))
           || (dec_is_fpu && c == 2 && now < div_free);
        exp_acc = dec_valid && !haz && n_stall && !flush && !rst;
        st = '0;
        if (exp_acc && dec_is_fpu) st[3-c] = 1'b1;
        wv = 1'b0;
        wr = '0;
        ws = '0;
        if (wb_at.exists(now)) begin
            wv = wb_at[now].rdv;
            wr = wb_at[now].rd;
            ws = wb_at[now].src;
        end
        busy  = (last_wb >= now) || (now < div_free);
        exp_v = {!haz, st, wv, wr, ws, busy};
    endtask

    task automatic model_commit();
        int L;
        int c;
        L = lat_of(dec_fop);
        c = cls_of(dec_fop);
        if (rst) begin
            model_clear();
        end else if (exp_acc && dec_is_fpu) begin
            wb_at[now + L] = '{dec_rd[6], dec_rd[5:0], 2'(c)};
            if (dec_rd[6]) pend_until[dec_rd[5:0]] = now + L;
            if (c == 2) div_free = now + 8;
            if (now + L > last_wb) last_wb = now + L;
        end
        now++;
    endtask

    task automatic step();
        model_commit();
        @(negedge clk);
    endtask

    task automatic drive(bit v, bit fpu, logic [2:0] fop, logic [5:0] r1,
                         logic [5:0] r2, bit r2en, logic [6:0] rd);
        dec_valid  = v;
        dec_is_fpu = fpu;
        dec_fop    = fop;
        dec_rs1    = r1;
        dec_rs2    = r2;
        dec_rs2_en = r2en;
        dec_rd     = rd;
        n_stall    = 1'b1;
        flush      = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic idle();
        drive(0, 0, 3'd0, 6'h00, 6'h00, 0, 7'h00);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_eval();
        #1;
        checks++;
        if (dut_v !== exp_v) begin
            errors++;
            $display("FAIL reset got=%h exp=%h", dut_v, exp_v);
        end
        checks++;
        if ({wb_valid, fpu_busy, iss_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_outs got=%b exp=001",
                     {wb_valid, fpu_busy, iss_ready});
        end
        step();
        idle();
    endtask

    task automatic test_add_wb();
        for (int k = 0; k < 6; k++) begin
            if (k == 0) drive(1, 1, 3'd0, 6'h02, 6'h03, 1, 7'h61);
            else drive(1, 0, 3'd7, 6'h21, 6'h00, 0, 7'h00);
            model_eval();
            #1;
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL add_wb cyc=%0d got=%h exp=%h", k, dut_v, exp_v);
            end
            if (k == 0) begin
                checks++;
                if (add_start !== 1'b1) begin
                    errors++;
                    $display("FAIL add_start got=%b exp=1", add_start);
                end
            end
            if (k == 2 || k == 4) begin
                checks++;
                if (iss_ready !== (k == 4)) begin
                    errors++;
                    $display("FAIL add_pend cyc=%0d got=%b exp=%b",
                             k, iss_ready, k == 4);
                end
            end
            if (k == 3) begin
                checks++;
                if ({wb_valid, wb_rd, wb_src} !== {1'b1, 6'h21, 2'b00}) begin
                    errors++;
                    $display("FAIL add_wb_port got=%b/%h/%b exp=1/21/00",
                             wb_valid, wb_rd, wb_src);
                end
            end
            step();
        end
        idle();
    endtask

    task automatic test_raw();
        for (int k = 0; k < 9; k++) begin
            if (k == 0) drive(1, 1, 3'd0, 6'h02, 6'h03, 1, 7'h61);
            else if (k < 3) drive(1, 0, 3'd0, 6'h01, 6'h00, 0, 7'h61);
            else if (k < 5) drive(1, 1, 3'd2, 6'h21, 6'h02, 1, 7'h62);
            else idle();
            model_eval();
            #1;
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL raw cyc=%0d got=%h exp=%h", k, dut_v, exp_v);
            end
            if (k == 1 || k == 3) begin
                checks++;
                if (iss_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL raw_stall cyc=%0d got=%b exp=0", k, iss_ready);
                end
            end
            if (k == 4) begin
                checks++;
                if (mul_start !== 1'b1) begin
                    errors++;
                    $display("FAIL raw_mul_start got=%b exp=1", mul_start);
                end
            end
            step();
        end
        idle();
    endtask

    task automatic test_slot();
        for (int k = 0; k < 7; k++) begin
            if (k == 0) drive(1, 1, 3'd0, 6'h02, 6'h03, 1, 7'h61);
            else if (k < 3) drive(1, 1, 3'd2, 6'h03, 6'h04, 1, 7'h62);
            else idle();
            model_eval();
            #1;
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL slot cyc=%0d got=%h exp=%h", k, dut_v, exp_v);
            end
            if (k == 1 || k == 2) begin
                checks++;
                if (mul_start !== (k == 2)) begin
                    errors++;
                    $display("FAIL slot_mul cyc=%0d got=%b exp=%b",
                             k, mul_start, k == 2);
                end
            end
            if (k == 4) begin
                checks++;
                if ({wb_valid, wb_rd, wb_src} !== {1'b1, 6'h22, 2'b01}) begin
                    errors++;
                    $display("FAIL slot_wb got=%b/%h/%b exp=1/22/01",
                             wb_valid, wb_rd, wb_src);
                end
            end
            step();
        end
        idle();
    endtask

    task automatic test_div();
        for (int k = 0; k < 18; k++) begin
            if (k == 0) drive(1, 1, 3'd3, 6'h04, 6'h00, 0, 7'h63);
            else if (k < 9) drive(1, 1, 3'd4, 6'h05, 6'h00, 0, 7'h64);
            else idle();
            model_eval();
            #1;
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL div cyc=%0d got=%h exp=%h", k, dut_v, exp_v);
            end
            if (k == 7 || k == 8) begin
                checks++;
                if (div_start !== (k == 8)) begin
                    errors++;
                    $display("FAIL div_start cyc=%0d got=%b exp=%b",
                             k, div_start, k == 8);
                end
            end
            if (k == 8 || k == 16) begin
                checks++;
                if ({wb_valid, wb_rd, wb_src} !==
                    {1'b1, (k == 8) ? 6'h23 : 6'h24, 2'b10}) begin
                    errors++;
                    $display("FAIL div_wb cyc=%0d got=%b/%h/%b", k,
                             wb_valid, wb_rd, wb_src);
                end
            end
            if (k == 17) begin
                checks++;
                if (fpu_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL div_idle got=%b exp=0", fpu_busy);
                end
            end
            step();
        end
        idle();
    endtask

    task automatic test_flush_stall();
        for (int k = 0; k < 6; k++) begin
            if (k == 0) drive(1, 1, 3'd0, 6'h02, 6'h03, 1, 7'h61);
            else if (k == 1) begin
                drive(1, 1, 3'd5, 6'h01, 6'h00, 0, 7'h65);
                flush = 1'b1;
            end else if (k == 2) begin
                drive(1, 1, 3'd2, 6'h01, 6'h02, 1, 7'h66);
                n_stall = 1'b0;
            end else if (k == 3) drive(1, 0, 3'd0, 6'h25, 6'h26, 1, 7'h00);
            else idle();
            model_eval();
            #1;
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL flush cyc=%0d got=%h exp=%h", k, dut_v, exp_v);
            end
            if (k == 1 || k == 2) begin
                checks++;
                if ({misc_start, mul_start} !== 2'b00) begin
                    errors++;
                    $display("FAIL flush_start cyc=%0d got=%b exp=00",
                             k, {misc_start, mul_start});
                end
            end
            if (k == 3) begin
                checks++;
                if ({iss_ready, wb_valid, wb_rd} !== {2'b11, 6'h21}) begin
                    errors++;
                    $display("FAIL flush_nopend got=%b/%b/%h exp=1/1/21",
                             iss_ready, wb_valid, wb_rd);
                end
            end
            step();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 16; k++) begin
            if (k == 0) drive(1, 1, 3'd3, 6'h04, 6'h00, 0, 7'h63);
            else if (k == 2) begin
                idle();
                rst = 1'b1;
            end else if (k == 3) drive(1, 0, 3'd0, 6'h23, 6'h00, 0, 7'h63);
            else if (k == 4) drive(1, 1, 3'd0, 6'h00, 6'h00, 1, 7'h40);
            else if (k == 5) drive(1, 0, 3'd0, 6'h00, 6'h00, 1, 7'h40);
            else if (k == 6) drive(1, 1, 3'd3, 6'h00, 6'h00, 0, 7'h67);
            else idle();
            model_eval();
            #1;
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL rstmid cyc=%0d got=%h exp=%h", k, dut_v, exp_v);
            end
            if (k == 3) begin
                checks++;
                if ({iss_ready, wb_valid, fpu_busy} !== 3'b100) begin
                    errors++;
                    $display("FAIL rstmid_clear got=%b exp=100",
                             {iss_ready, wb_valid, fpu_busy});
                end
            end
            if (k == 5 || k == 6) begin
                checks++;
                if ((k == 5 ? iss_ready : div_start) !== 1'b1) begin
                    errors++;
                    $display("FAIL rstmid_x0_div cyc=%0d got=%b exp=1", k,
                             k == 5 ? iss_ready : div_start);
                end
            end
            if (k == 8) begin
                checks++;
                if (wb_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rstmid_dropped got=%b exp=0", wb_valid);
                end
            end
            step();
        end
        idle();
    endtask

    function automatic logic [5:0] pick_reg();
        return {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))};
    endfunction

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            dec_valid  = ($urandom_range(0, 99) < 80);
            dec_is_fpu = ($urandom_range(0, 99) < 80);
            dec_fop    = 3'($urandom_range(0, 7));
            dec_rs1    = pick_reg();
            dec_rs2    = pick_reg();
            dec_rs2_en = 1'($urandom_range(0, 1));
            dec_rd     = {1'($urandom_range(0, 3) != 0), pick_reg()};
            n_stall    = ($urandom_range(0, 99) < 85);
            flush      = ($urandom_range(0, 99) < 10);
            rst        = ($urandom_range(0, 99) < 2);
            model_eval();
            #1;
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", k, dut_v, exp_v);
            end
            step();
        end
        idle();
    endtask

    initial begin
        model_clear();
        now = 0;
        repeat (2) @(negedge clk);
        test_reset();
        test_add_wb();
        test_raw();
        test_slot();
        test_div();
        test_flush_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
